// File: rtl/if_id_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg_pkg
// Shared definitions for the IF/ID pipeline register slice:
//   - if_id_state_t : two-state control FSM encoding (RUN, HALTED)
//   - DEF_PC_W      : default PC field width
//   - DEF_INSTR_W   : default instruction field width
//   - DEF_NOP_INSTR : default bubble encoding driven on instr_out
//   - PERF_CNT_W    : width of the optional performance counters
// -----------------------------------------------------------------------------
package if_id_pipe_reg_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } if_id_state_t;

    localparam int          DEF_PC_W      = 16;
    localparam int          DEF_INSTR_W   = 16;
    localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;
    localparam int          PERF_CNT_W    = 16;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg_if
// Bundle of fetch-side inputs, hazard/control inputs and decode-side outputs
// of the IF/ID pipeline register.
//   master : fetch/control side (drives pc_in..resume, observes outputs)
//   slave  : the pipeline register itself
// Signals:
//   pc_in, instr_in, valid_in, flush_in : fetch-stage slot
//   stall, flush, halt, resume          : hazard / control requests
//   pc_out, instr_out, valid_out,
//   flush_out, halted                   : registered decode-side view
// -----------------------------------------------------------------------------
interface if_id_pipe_reg_if
    import if_id_pipe_reg_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();

    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               valid_in;
    logic               flush_in;
    logic               stall;
    logic               flush;
    logic               halt;
    logic               resume;

    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic               valid_out;
    logic               flush_out;
    logic               halted;

    modport master (
        output pc_in, instr_in, valid_in, flush_in,
        output stall, flush, halt, resume,
        input  pc_out, instr_out, valid_out, flush_out, halted
    );

    modport slave (
        input  pc_in, instr_in, valid_in, flush_in,
        input  stall, flush, halt, resume,
        output pc_out, instr_out, valid_out, flush_out, halted
    );

endinterface

// File: rtl/if_id_pipe_reg_pipe_perf_ctr.sv
// -----------------------------------------------------------------------------
// pipe_perf_ctr
// Saturating event counter; sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   inc   : count one event this cycle
//   count : current count
// -----------------------------------------------------------------------------
module pipe_perf_ctr
    import if_id_pipe_reg_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] count
);

    logic [PERF_CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {PERF_CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
// IF/ID pipeline register with stall, flush (bubble insert) and halt/resume.
// One-cycle latency from the fetch slot to the decode-side outputs.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   bus        : if_id_pipe_reg_if.slave (fetch inputs, controls, outputs)
//   stall_cnt  : (IF_ID_PERF_CNT_EN only) cycles in RUN held by stall
//   bubble_cnt : (IF_ID_PERF_CNT_EN only) edges that loaded a bubble
// Build option: define IF_ID_PERF_CNT_EN to add the saturating counters.
// Priority in RUN: halt > flush > stall > load.
// -----------------------------------------------------------------------------
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst,
    if_id_pipe_reg_if.slave       bus
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

    if_id_state_t       state_reg, state_next;
    logic [PC_W-1:0]    pc_reg,    pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic               valid_reg, valid_next;
    logic               flush_reg, flush_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
            flush_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            flush_reg <= flush_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        flush_next = flush_reg;

        case (state_reg)
            RUN: begin
                if (bus.halt) begin
                    // Bubble in, but keep the PC of the last real slot.
                    state_next = HALTED;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    flush_next = 1'b0;
                end else if (bus.flush) begin
                    pc_next    = bus.pc_in;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    flush_next = 1'b0;
                end else if (bus.stall) begin
                    // hold everything
                end else begin
                    pc_next    = bus.pc_in;
                    instr_next = bus.valid_in ? bus.instr_in : NOP_INSTR;
                    valid_next = bus.valid_in;
                    flush_next = bus.flush_in;
                end
            end
            HALTED: begin
                // Force the bubble so nothing stale can leak while parked.
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
                flush_next = 1'b0;
                // The resume edge only changes state; loading starts next edge.
                if (bus.resume && !bus.halt) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign bus.pc_out    = pc_reg;
    assign bus.instr_out = instr_reg;
    assign bus.valid_out = valid_reg;
    assign bus.flush_out = flush_reg;
    assign bus.halted    = (state_reg == HALTED);

`ifdef IF_ID_PERF_CNT_EN
    logic stall_evt;
    logic bubble_evt;

    // A stall only counts when nothing of higher priority overrides it.
    assign stall_evt  = (state_reg == RUN) && !bus.halt && !bus.flush && bus.stall;
    // Bubble loads: halt entry, flush, or an unstalled load of an empty slot.
    assign bubble_evt = (state_reg == RUN) &&
                        (bus.halt || bus.flush || (!bus.stall && !bus.valid_in));

    pipe_perf_ctr u_stall_ctr (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_evt),
        .count (stall_cnt)
    );

    pipe_perf_ctr u_bubble_ctr (
        .clk   (clk),
        .clr   (rst),
        .inc   (bubble_evt),
        .count (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe_reg
// Directed self-checking bench for if_id_pipe_reg. Each scenario task drives
// inputs just after a rising edge and checks outputs 1 time unit after the
// following rising edge. Counter scenario is built only with IF_ID_PERF_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_id_pipe_reg;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
`endif

    if_id_pipe_reg_if #(.PC_W(16), .INSTR_W(16)) bus ();

    if_id_pipe_reg dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pc_in    = 16'h0000;
        bus.instr_in = 16'h0000;
        bus.valid_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.halt     = 1'b0;
        bus.resume   = 1'b0;
    endtask

    // Compares all five outputs against expected values; used inline per scenario.
    task automatic expect_all(input string name, input logic [15:0] pc, input logic [15:0] instr,
                              input logic valid, input logic fl, input logic hlt);
        checks++;
        if (bus.pc_out !== pc || bus.instr_out !== instr || bus.valid_out !== valid ||
            bus.flush_out !== fl || bus.halted !== hlt) begin
            errors++;
            $display("FAIL %s: got pc=%h instr=%h valid=%b flush=%b halted=%b, want pc=%h instr=%h valid=%b flush=%b halted=%b",
                     name, bus.pc_out, bus.instr_out, bus.valid_out, bus.flush_out, bus.halted,
                     pc, instr, valid, fl, hlt);
        end else begin
            $display("ok   %s: pc=%h instr=%h valid=%b flush=%b halted=%b",
                     name, bus.pc_out, bus.instr_out, bus.valid_out, bus.flush_out, bus.halted);
        end
    endtask

    task automatic test_reset();
        // Reset with every control active and junk data.
        bus.pc_in = 16'hFFFF; bus.instr_in = 16'hDEAD; bus.valid_in = 1'b1;
        bus.flush_in = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        bus.halt = 1'b1; bus.resume = 1'b1;
        rst = 1'b1;
        tick();
        expect_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.pc_in = 16'h0040; bus.instr_in = 16'h1234; bus.valid_in = 1'b1;
        tick();
        expect_all("load", 16'h0040, 16'h1234, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        bus.stall = 1'b1; bus.pc_in = 16'h0044; bus.instr_in = 16'hAAAA; bus.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all($sformatf("stall_hold%0d", i), 16'h0040, 16'h1234, 1'b1, 1'b0, 1'b0);
        end
        bus.stall = 1'b0;
        tick();
        expect_all("stall_release", 16'h0044, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush_over_stall();
        bus.stall = 1'b1; bus.flush = 1'b1;
        bus.pc_in = 16'h0050; bus.instr_in = 16'h5555; bus.valid_in = 1'b1; bus.flush_in = 1'b1;
        tick();
        expect_all("flush_over_stall", 16'h0050, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle_inputs();
    endtask

    task automatic test_invalid_load();
        bus.pc_in = 16'h0060; bus.instr_in = 16'hBEEF; bus.valid_in = 1'b0;
        tick();
        expect_all("invalid_load", 16'h0060, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_tag();
        bus.pc_in = 16'h0070; bus.instr_in = 16'h1111; bus.valid_in = 1'b1; bus.flush_in = 1'b1;
        tick();
        expect_all("flush_tag_fwd", 16'h0070, 16'h1111, 1'b1, 1'b1, 1'b0);
        bus.flush = 1'b1; bus.pc_in = 16'h0074;
        tick();
        expect_all("flush_tag_killed", 16'h0074, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle_inputs();
    endtask

    task automatic test_halt();
        bus.pc_in = 16'h0080; bus.instr_in = 16'h2222; bus.valid_in = 1'b1;
        tick();
        expect_all("pre_halt_load", 16'h0080, 16'h2222, 1'b1, 1'b0, 1'b0);
        bus.halt = 1'b1; bus.pc_in = 16'h0090; bus.instr_in = 16'h3333;
        tick();
        expect_all("halt_enter", 16'h0080, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus.halt = 1'b0; bus.flush = 1'b1; bus.stall = 1'b1; bus.pc_in = 16'h00A0;
        tick();
        expect_all("halted_ignores_ctl", 16'h0080, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b0; bus.stall = 1'b0;
        bus.resume = 1'b1; bus.halt = 1'b1;
        tick();
        expect_all("resume_and_halt", 16'h0080, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus.halt = 1'b0; bus.pc_in = 16'h00B0; bus.instr_in = 16'h4444; bus.valid_in = 1'b1;
        tick();
        expect_all("resume_edge", 16'h0080, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus.resume = 1'b0;
        tick();
        expect_all("post_resume_load", 16'h00B0, 16'h4444, 1'b1, 1'b0, 1'b0);
        idle_inputs();
    endtask

    task automatic test_reset_mid_state();
        bus.halt = 1'b1;
        tick();
        expect_all("halt_before_rst", 16'h00B0, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus.stall = 1'b1; rst = 1'b1;
        tick();
        expect_all("reset_mid_halt", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_inputs();
        bus.pc_in = 16'h00C0; bus.instr_in = 16'h6666; bus.valid_in = 1'b1; bus.flush_in = 1'b1;
        tick();
        expect_all("load_before_rst", 16'h00C0, 16'h6666, 1'b1, 1'b1, 1'b0);
        bus.stall = 1'b1; rst = 1'b1;
        tick();
        expect_all("reset_mid_stall", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pc;
        logic [15:0] ins;
        for (int i = 0; i < 6; i++) begin
            pc  = 16'h0100 + 16'(i * 4);
            ins = 16'h7000 + 16'(i);
            bus.pc_in = pc; bus.instr_in = ins; bus.valid_in = 1'b1;
            bus.flush_in = (i == 3);
            tick();
            expect_all($sformatf("b2b%0d", i), pc, ins, 1'b1, (i == 3), 1'b0);
        end
        idle_inputs();
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 16'h0000 || bubble_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_reset: got stall=%h bubble=%h, want 0000 0000", stall_cnt, bubble_cnt);
        end else $display("ok   cnt_reset");
        bus.valid_in = 1'b1; bus.instr_in = 16'h1234; bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.stall = 1'b0; bus.flush = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        bus.flush = 1'b0;
        checks++;
        if (stall_cnt !== 16'd5 || bubble_cnt !== 16'd2) begin
            errors++;
            $display("FAIL cnt_counts: got stall=%0d bubble=%0d, want 5 2", stall_cnt, bubble_cnt);
        end else $display("ok   cnt_counts: stall=%0d bubble=%0d", stall_cnt, bubble_cnt);
        bus.stall = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'd2) begin
            errors++;
            $display("FAIL cnt_saturate: got stall=%h bubble=%0d, want FFFF 2", stall_cnt, bubble_cnt);
        end else $display("ok   cnt_saturate: stall=%h", stall_cnt);
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load();
        test_stall();
        test_flush_over_stall();
        test_invalid_load();
        test_flush_tag();
        test_halt();
        test_reset_mid_state();
        test_back_to_back();
`ifdef IF_ID_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
